regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Schedules up to NREQ write-back requesters onto the two write ports of the banked 4r2w register file
//   (even bank: addr[0]=0, odd bank: addr[0]=1). Grants at most one write per bank per cycle, so the file's
//   port-conflict condition is never driven. After reset it runs a zero-init sequence over all 32 registers.
//   Sits between the execute/LSU write-back stages and the register file write ports.
// PARAMETERS
//   WIDTH      32  data width of one register
//   NREQ       3   number of write-back requesters (2..4)
//   INIT_ZERO  1   1: clear r0..r31 after reset before accepting requests; 0: start directly in RUN
// PORTS
//   clk            in   1           clock
//   rst            in   1           asynchronous reset, active high
//   req_valid_i    in   NREQ        requester i has a write pending
//   req_addr_i     in   NREQ*5      destination register of requester i, slice [5i+4:5i]
//   req_data_i     in   NREQ*WIDTH  write data of requester i, slice [WIDTH*i+WIDTH-1:WIDTH*i]
//   req_ready_o    out  NREQ        requester i accepted this cycle (transfer = valid & ready)
//   wa0_o/wa1_o    out  5           write address, port 0 / port 1
//   wd0_o/wd1_o    out  WIDTH       write data, port 0 / port 1
//   we0_o/we1_o    out  1           write enable, port 0 / port 1
//   init_done_o    out  1           high once the init sequence is complete (state RUN)
// BEHAVIOUR
//   Reset (async, rst=1): state=INIT (RUN if INIT_ZERO=0), init_cnt_q=0, rr_q=0, we*/wa*/wd*=0,
//     req_ready_o=0, init_done_o=0. Reset asserted mid-init or mid-run aborts immediately; any grant
//     not yet registered is discarded (the requester still holds valid, so no data is lost).
//   States:
//     INIT: each cycle registers we0=1,wa0={init_cnt_q,1'b0},wd0=0 and we1=1,wa1={init_cnt_q,1'b1},wd1=0;
//       init_cnt_q (4 bit) increments; when init_cnt_q==15 -> RUN. That is 16 cycles, all 32 registers
//       written. req_ready_o=0 throughout.
//     RUN: arbitration as below; stays in RUN until reset.
//   Arbitration (RUN, combinational, one cycle):
//     - Scan requesters in round-robin order rr_q, rr_q+1, ... mod NREQ.
//     - First valid requester -> slot A. Next valid requester whose addr[0] differs from A's -> slot B.
//       All others: ready=0 (stall, hold request).
//     - Requester with addr==0: ready=1 whenever it is scanned before any stall decision (does not consume a
//       slot, produces no write); r0 is never written in RUN.
//     - Slot A drives port 0, slot B drives port 1.
//     - rr_q <= (index of last granted slot-holder + 1) mod NREQ; unchanged if nothing granted.
//   Output timing: port outputs are registered; handshake in cycle N -> we*_o=1 with addr/data in N+1;
//     regfile write completes at edge N+2. we*_o=0 in any cycle without a grant (wa/wd hold last value).
//   Invariant: we0_o & we1_o -> wa0_o[0] != wa1_o[0]. Two requesters to the same register in one cycle:
//     only the higher-priority one in scan order is accepted; the other follows in a later cycle.
//   Starvation: a valid requester is granted within NREQ cycles of RUN.
//   init_done_o = (state==RUN), registered.
// TESTING
//   1. Reset release, INIT_ZERO=1 -> 16 cycles of we0=we1=1, wa0=0,2..30, wa1=1,3..31, wd=0; ready=0;
//      init_done_o rises on cycle 17.
//   2. RUN, req0 addr 4 / req1 addr 7 both valid -> both ready; next cycle wa0=4, wa1=7, we0=we1=1.
//   3. RUN, req0 addr 4 / req1 addr 6 / rr_q=0 -> only req0 ready; req1 granted next cycle, we1=0 both
//      cycles.
//   4. All three valid to even addresses for 6 cycles -> grants rotate 0,1,2,0,1,2; none waits >3 cycles.
//   5. req2 addr 0 valid -> ready=1, no we pulse; register file r0 stays 0.
//   6. Assert rst during INIT cycle 8 and during a RUN grant -> outputs 0 at once; INIT restarts from
//      cnt 0; held requests reissue correctly.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Purpose  : Bundle of write-back requester handshake signals and the two
//            register-file write ports driven by regfile_wb_arbiter.
// Ports    : req_valid_i / req_addr_i / req_data_i  requester side (to arbiter)
//            req_ready_o                            per-requester accept
//            wa0_o/wd0_o/we0_o, wa1_o/wd1_o/we1_o   register-file write ports
//            init_done_o                            zero-init sequence finished
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 3
);
   logic [NREQ-1:0]       req_valid_i;
   logic [NREQ*5-1:0]     req_addr_i;
   logic [NREQ*WIDTH-1:0] req_data_i;
   logic [NREQ-1:0]       req_ready_o;
   logic [4:0]            wa0_o;
   logic [4:0]            wa1_o;
   logic [WIDTH-1:0]      wd0_o;
   logic [WIDTH-1:0]      wd1_o;
   logic                  we0_o;
   logic                  we1_o;
   logic                  init_done_o;

   // Arbiter side
   modport slave (
      input  req_valid_i, req_addr_i, req_data_i,
      output req_ready_o, wa0_o, wa1_o, wd0_o, wd1_o, we0_o, we1_o, init_done_o
   );

   // Requester / register-file side
   modport master (
      output req_valid_i, req_addr_i, req_data_i,
      input  req_ready_o, wa0_o, wa1_o, wd0_o, wd1_o, we0_o, we1_o, init_done_o
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin scheduler of NREQ write-back requesters onto the two
//            write ports of a banked 4r2w register file (port 0 / port 1 never
//            hit the same bank in one cycle). Clears r0..r31 after reset.
// Ports    : clk  - clock
//            rst  - asynchronous reset, active high
//            bus  - regfile_wb_arbiter_if.slave (requests, ready, write ports,
//                   init_done)
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int WIDTH     = 32,
   parameter int NREQ      = 3,
   parameter int INIT_ZERO = 1
) (
   input  logic                clk,
   input  logic                rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int           RRW    = $clog2(NREQ);
   localparam logic [RRW:0] c_nreq = (RRW+1)'(NREQ);

   localparam logic [0:0] c_ST_INIT = 1'b0;
   localparam logic [0:0] c_ST_RUN  = 1'b1;
   localparam logic [0:0] c_ST_RST  = (INIT_ZERO != 0) ? c_ST_INIT : c_ST_RUN;

   // State / control registers
   logic [0:0]       r_state;
   logic [3:0]       r_init_cnt;
   logic [RRW-1:0]   r_rr;
   logic             r_init_done;

   // Registered write ports
   logic             r_we0, r_we1;
   logic [4:0]       r_wa0, r_wa1;
   logic [WIDTH-1:0] r_wd0, r_wd1;

   // Combinational
   logic [0:0]       w_state_nxt;
   logic [3:0]       w_cnt_nxt;
   logic [RRW-1:0]   w_rr_nxt;
   logic [NREQ-1:0]  w_arb_rdy;
   logic             w_a_vld, w_b_vld;
   logic [RRW-1:0]   w_a_idx, w_b_idx;
   logic             w_run;
   logic             w_we0_nxt, w_we1_nxt;
   logic [4:0]       w_wa0_nxt, w_wa1_nxt;
   logic [WIDTH-1:0] w_wd0_nxt, w_wd1_nxt;

   logic [4:0]       w_addr [NREQ];
   logic [WIDTH-1:0] w_data [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_addr[g] = bus.req_addr_i[5*g +: 5];
      assign w_data[g] = bus.req_data_i[WIDTH*g +: WIDTH];
   end

   // Reduce a value in 0..2*NREQ-1 to a requester index (mod NREQ).
   function automatic logic [RRW-1:0] f_wrap(input logic [RRW:0] v);
      logic [RRW:0] t;
      t = v;
      if (t >= c_nreq) t = t - c_nreq;
      return t[RRW-1:0];
   endfunction

   // Round-robin scan starting at r_rr. Slot A takes the first writer, slot B
   // the next writer in the opposite bank. Writes to r0 are acknowledged but
   // dropped; they only get through while nobody ahead of them has stalled,
   // so a stalled requester is never overtaken by an r0 discard behind it.
   always_comb begin : p_arb
      logic [RRW-1:0] w_idx;
      logic           w_stall;
      w_arb_rdy = '0;
      w_a_vld   = 1'b0;
      w_b_vld   = 1'b0;
      w_a_idx   = '0;
      w_b_idx   = '0;
      w_stall   = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = f_wrap({1'b0, r_rr} + (RRW+1)'(k));
         if (bus.req_valid_i[w_idx]) begin
            if (w_addr[w_idx] == 5'd0) begin
               if (!w_stall) w_arb_rdy[w_idx] = 1'b1;
            end else if (!w_a_vld) begin
               w_a_vld          = 1'b1;
               w_a_idx          = w_idx;
               w_arb_rdy[w_idx] = 1'b1;
            end else if (!w_b_vld && (w_addr[w_idx][0] != w_addr[w_a_idx][0])) begin
               w_b_vld          = 1'b1;
               w_b_idx          = w_idx;
               w_arb_rdy[w_idx] = 1'b1;
            end else begin
               w_stall = 1'b1;
            end
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin : p_state
      if (rst) begin
         r_state     <= c_ST_RST;
         r_init_cnt  <= 4'd0;
         r_rr        <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_cnt  <= w_cnt_nxt;
         r_rr        <= w_rr_nxt;
         r_init_done <= (r_state == c_ST_RUN);
      end
   end

   // FSM: next state
   always_comb begin : p_next
      w_state_nxt = r_state;
      w_cnt_nxt   = r_init_cnt;
      w_rr_nxt    = r_rr;
      case (r_state)
         c_ST_INIT: begin
            w_cnt_nxt = r_init_cnt + 4'd1;
            if (r_init_cnt == 4'd15) w_state_nxt = c_ST_RUN;
         end
         default: begin
            // Priority moves past the last granted slot-holder (B follows A in scan order).
            if (w_b_vld)      w_rr_nxt = f_wrap({1'b0, w_b_idx} + (RRW+1)'(1));
            else if (w_a_vld) w_rr_nxt = f_wrap({1'b0, w_a_idx} + (RRW+1)'(1));
         end
      endcase
   end

   // FSM: outputs
   always_comb begin : p_out
      // rst gate keeps ready low during reset when starting directly in RUN.
      w_run     = (r_state == c_ST_RUN) && !rst;
      w_we0_nxt = 1'b0;
      w_we1_nxt = 1'b0;
      w_wa0_nxt = r_wa0;
      w_wa1_nxt = r_wa1;
      w_wd0_nxt = r_wd0;
      w_wd1_nxt = r_wd1;
      if (r_state == c_ST_INIT) begin
         w_we0_nxt = 1'b1;
         w_we1_nxt = 1'b1;
         w_wa0_nxt = {r_init_cnt, 1'b0};
         w_wa1_nxt = {r_init_cnt, 1'b1};
         w_wd0_nxt = '0;
         w_wd1_nxt = '0;
      end else begin
         if (w_a_vld) begin
            w_we0_nxt = 1'b1;
            w_wa0_nxt = w_addr[w_a_idx];
            w_wd0_nxt = w_data[w_a_idx];
         end
         if (w_b_vld) begin
            w_we1_nxt = 1'b1;
            w_wa1_nxt = w_addr[w_b_idx];
            w_wd1_nxt = w_data[w_b_idx];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin : p_ports
      if (rst) begin
         r_we0 <= 1'b0;
         r_we1 <= 1'b0;
         r_wa0 <= '0;
         r_wa1 <= '0;
         r_wd0 <= '0;
         r_wd1 <= '0;
      end else begin
         r_we0 <= w_we0_nxt;
         r_we1 <= w_we1_nxt;
         r_wa0 <= w_wa0_nxt;
         r_wa1 <= w_wa1_nxt;
         r_wd0 <= w_wd0_nxt;
         r_wd1 <= w_wd1_nxt;
      end
   end

   assign bus.req_ready_o = w_run ? w_arb_rdy : '0;
   assign bus.we0_o       = r_we0;
   assign bus.we1_o       = r_we1;
   assign bus.wa0_o       = r_wa0;
   assign bus.wa1_o       = r_wa1;
   assign bus.wd0_o       = r_wd0;
   assign bus.wd1_o       = r_wd1;
   assign bus.init_done_o = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter (WIDTH=32, NREQ=3,
//            INIT_ZERO=1): init sequence, table of arbitration vectors with a
//            write scoreboard, and asynchronous reset during INIT and RUN.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;
   localparam int WIDTH = 32;
   localparam int NREQ  = 3;
   localparam int NV    = 19;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   regfile_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .INIT_ZERO(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string      name;
      logic [2:0] v;
      logic [4:0] a0, a1, a2;
      logic [2:0] rdy;
      int         ga;   // requester expected on port 0, -1 none
      int         gb;   // requester expected on port 1, -1 none
   } vec_t;

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
   } wr_t;

   vec_t vecs [NV];
   wr_t  sb [$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] dat(input int i, input logic [4:0] a);
      return {8'hD0, 8'(i), 11'h0, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2);
      bus.req_valid_i = v;
      bus.req_addr_i  = {a2, a1, a0};
      bus.req_data_i  = {dat(2, a2), dat(1, a1), dat(0, a0)};
   endtask

   // Called just after an active edge; consumes one clock cycle.
   task automatic apply(input vec_t t);
      logic [4:0] a [3];
      wr_t e;
      a[0] = t.a0; a[1] = t.a1; a[2] = t.a2;
      drive(t.v, t.a0, t.a1, t.a2);
      e.we0 = 1'b0; e.wa0 = '0; e.wd0 = '0;
      e.we1 = 1'b0; e.wa1 = '0; e.wd1 = '0;
      if (t.ga >= 0) begin
         e.we0 = 1'b1; e.wa0 = a[t.ga]; e.wd0 = dat(t.ga, a[t.ga]);
      end
      if (t.gb >= 0) begin
         e.we1 = 1'b1; e.wa1 = a[t.gb]; e.wd1 = dat(t.gb, a[t.gb]);
      end
      sb.push_back(e);
      #3;
      chk({t.name, "_ready"}, 32'(bus.req_ready_o), 32'(t.rdy));
      @(posedge clk); #1;
      e = sb.pop_front();
      chk({t.name, "_we0"}, 32'(bus.we0_o), 32'(e.we0));
      chk({t.name, "_we1"}, 32'(bus.we1_o), 32'(e.we1));
      if (e.we0) begin
         chk({t.name, "_wa0"}, 32'(bus.wa0_o), 32'(e.wa0));
         chk({t.name, "_wd0"}, bus.wd0_o, e.wd0);
      end
      if (e.we1) begin
         chk({t.name, "_wa1"}, 32'(bus.wa1_o), 32'(e.wa1));
         chk({t.name, "_wd1"}, bus.wd1_o, e.wd1);
      end
   endtask

   // Started between edges right after reset release. held=1: req0 addr 4 and
   // req1 addr 7 stay valid throughout and must be accepted in the first RUN cycle.
   task automatic init_seq(input bit held);
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         chk("init_we0", 32'(bus.we0_o), 32'd1);
         chk("init_we1", 32'(bus.we1_o), 32'd1);
         chk("init_wa0", 32'(bus.wa0_o), 32'(2*k));
         chk("init_wa1", 32'(bus.wa1_o), 32'(2*k+1));
         chk("init_wd0", bus.wd0_o, 32'd0);
         chk("init_wd1", bus.wd1_o, 32'd0);
         chk("init_done_low", 32'(bus.init_done_o), 32'd0);
         if (k < 15) chk("init_ready", 32'(bus.req_ready_o), 32'd0);
      end
      chk("run_first_ready", 32'(bus.req_ready_o), held ? 32'd3 : 32'd0);
      @(posedge clk); #1;
      chk("init_done_high", 32'(bus.init_done_o), 32'd1);
      if (held) begin
         chk("reissue_we0", 32'(bus.we0_o), 32'd1);
         chk("reissue_wa0", 32'(bus.wa0_o), 32'd4);
         chk("reissue_wd0", bus.wd0_o, dat(0, 5'd4));
         chk("reissue_we1", 32'(bus.we1_o), 32'd1);
         chk("reissue_wa1", 32'(bus.wa1_o), 32'd7);
         chk("reissue_wd1", bus.wd1_o, dat(1, 5'd7));
      end else begin
         chk("post_init_we0", 32'(bus.we0_o), 32'd0);
         chk("post_init_we1", 32'(bus.we1_o), 32'd0);
      end
      drive(3'b000, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      drive(3'b000, 5'd0, 5'd0, 5'd0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we0", 32'(bus.we0_o), 32'd0);
      chk("rst_we1", 32'(bus.we1_o), 32'd0);
      chk("rst_wa0", 32'(bus.wa0_o), 32'd0);
      chk("rst_wa1", 32'(bus.wa1_o), 32'd0);
      chk("rst_wd0", bus.wd0_o, 32'd0);
      chk("rst_wd1", bus.wd1_o, 32'd0);
      chk("rst_init_done", 32'(bus.init_done_o), 32'd0);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      init_seq(1'b0);

      // Round-robin pointer (rr) noted after each vector; starts at 0.
      vecs[0]  = '{"both_banks",     3'b011, 5'd4, 5'd7, 5'd0,  3'b011,  0,  1}; // rr2
      vecs[1]  = '{"single_r2",      3'b100, 5'd0, 5'd0, 5'd9,  3'b100,  2, -1}; // rr0
      vecs[2]  = '{"same_bank",      3'b011, 5'd4, 5'd6, 5'd0,  3'b001,  0, -1}; // rr1
      vecs[3]  = '{"same_bank_next", 3'b010, 5'd4, 5'd6, 5'd0,  3'b010,  1, -1}; // rr2
      vecs[4]  = '{"idle",           3'b000, 5'd4, 5'd6, 5'd0,  3'b000, -1, -1}; // rr2
      vecs[5]  = '{"single_r2b",     3'b100, 5'd0, 5'd0, 5'd12, 3'b100,  2, -1}; // rr0
      vecs[6]  = '{"rot0",           3'b111, 5'd2, 5'd8, 5'd10, 3'b001,  0, -1}; // rr1
      vecs[7]  = '{"rot1",           3'b111, 5'd2, 5'd8, 5'd10, 3'b010,  1, -1}; // rr2
      vecs[8]  = '{"rot2",           3'b111, 5'd2, 5'd8, 5'd10, 3'b100,  2, -1}; // rr0
      vecs[9]  = '{"rot3",           3'b111, 5'd2, 5'd8, 5'd10, 3'b001,  0, -1}; // rr1
      vecs[10] = '{"rot4",           3'b111, 5'd2, 5'd8, 5'd10, 3'b010,  1, -1}; // rr2
      vecs[11] = '{"rot5",           3'b111, 5'd2, 5'd8, 5'd10, 3'b100,  2, -1}; // rr0
      vecs[12] = '{"r0_alone",       3'b100, 5'd0, 5'd0, 5'd0,  3'b100, -1, -1}; // rr0
      vecs[13] = '{"r0_after_stall", 3'b111, 5'd3, 5'd5, 5'd0,  3'b001,  0, -1}; // rr1
      vecs[14] = '{"r0_pre_stall",   3'b111, 5'd3, 5'd5, 5'd0,  3'b110,  1, -1}; // rr2
      vecs[15] = '{"r0_first",       3'b101, 5'd3, 5'd5, 5'd0,  3'b101,  0, -1}; // rr1
      vecs[16] = '{"odd_then_even",  3'b110, 5'd0, 5'd5, 5'd6,  3'b110,  1,  2}; // rr0
      vecs[17] = '{"three_mix",      3'b111, 5'd1, 5'd2, 5'd3,  3'b011,  0,  1}; // rr2
      vecs[18] = '{"b_after_stall",  3'b111, 5'd1, 5'd2, 5'd3,  3'b110,  2,  1}; // rr2
      for (int i = 0; i < NV; i++) apply(vecs[i]);
      drive(3'b000, 5'd0, 5'd0, 5'd0);

      // Reset from RUN, then again in the middle of INIT.
      #2 rst = 1'b1;
      #1 chk("rst_run_init_done", 32'(bus.init_done_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_mid_init_we0", 32'(bus.we0_o), 32'd0);
      chk("rst_mid_init_we1", 32'(bus.we1_o), 32'd0);
      chk("rst_mid_init_wa0", 32'(bus.wa0_o), 32'd0);
      chk("rst_mid_init_wa1", 32'(bus.wa1_o), 32'd0);
      chk("rst_mid_init_done", 32'(bus.init_done_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      init_seq(1'b0);

      // Reset while a grant is pending; the requests stay valid and must be
      // accepted once the new init sequence completes.
      drive(3'b011, 5'd4, 5'd7, 5'd0);
      #2 chk("pre_rst_ready", 32'(bus.req_ready_o), 32'd3);
      rst = 1'b1;
      #1;
      chk("rst_grant_ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst_grant_we0", 32'(bus.we0_o), 32'd0);
      chk("rst_grant_we1", 32'(bus.we1_o), 32'd0);
      @(posedge clk); #1;
      chk("rst_grant_no_write", 32'(bus.we0_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      init_seq(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
